// File: rtl/matvec_pkg.sv
// matvec_pkg: state encoding and fixed-point width, rounding and saturation helpers for matvec_fsl.
package matvec_pkg;

   localparam int MAX_W = 128;
   localparam logic [MAX_W-1:0] ONE = {{(MAX_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_V, COMPUTE, EMIT} state_t;

   function automatic int idx_w(input int dim);
      return $clog2(dim);
   endfunction

   function automatic int acc_w(input int data_w, input int dim);
      return 2 * data_w + $clog2(dim);
   endfunction

   function automatic logic [MAX_W-1:0] rnd_const(input int frac);
      return ONE << (frac - 1);
   endfunction

   // True when v lies outside the signed dw-bit range and must be clamped.
   function automatic logic sat_ovf(input logic signed [MAX_W-1:0] v, input int dw);
      logic signed [MAX_W-1:0] hi;
      hi = (ONE << (dw - 1)) - ONE;
      return v > hi || v < ~hi;
   endfunction

endpackage

// File: rtl/fixed_mac.sv
// fixed_mac: signed multiply-accumulate with clear; res_o/sat_o give the rounded, saturated
// value of the sum including the current product, so the last MAC of a row can be stored directly.
module fixed_mac
   import matvec_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 16,
   parameter int ACC_W     = 66
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     en_i,
   input  logic                     clr_i,
   input  logic signed [DATA_W-1:0] a_i,
   input  logic signed [DATA_W-1:0] b_i,
   output logic        [DATA_W-1:0] res_o,
   output logic                     sat_o
);

   localparam logic [MAX_W-1:0] RC = rnd_const(FRAC_BITS);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_q, acc_d, rnd, sh;
   logic signed [MAX_W-1:0]    wide;

   always_comb begin
      prod  = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
      acc_d = (clr_i ? '0 : acc_q) + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      rnd   = acc_d + RC[ACC_W-1:0];
      sh    = rnd >>> FRAC_BITS;
      wide  = {{(MAX_W-ACC_W){sh[ACC_W-1]}}, sh};
      sat_o = sat_ovf(wide, DATA_W);
      res_o = sat_o ? {sh[ACC_W-1], {(DATA_W-1){~sh[ACC_W-1]}}} : sh[DATA_W-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) acc_q <= '0;
      else if (en_i) acc_q <= acc_d;

endmodule

// File: rtl/matvec_fsl.sv
// matvec_fsl: DIMxDIM fixed-point matrix-vector multiplier on an FSL slave/master pair.
// A Control=1 word starts a matrix load; the matrix is then reused for every streamed vector.
module matvec_fsl
   import matvec_pkg::*;
#(
   parameter int DIM       = 4,
   parameter int DATA_W    = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic              FSL_Clk,
   input  logic              FSL_Rst,
   input  logic [DATA_W-1:0] FSL_S_Data,
   input  logic              FSL_S_Control,
   input  logic              FSL_S_Exists,
   output logic              FSL_S_Read,
   output logic [DATA_W-1:0] FSL_M_Data,
   output logic              FSL_M_Control,
   output logic              FSL_M_Write,
   input  logic              FSL_M_Full
);

   localparam int IW    = idx_w(DIM);
   localparam int ACC_W = acc_w(DATA_W, DIM);
   localparam logic [IW-1:0] LAST = IW'(DIM - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     r_q, r_d, c_q, c_d, r_nx, c_nx;
   logic [DATA_W-1:0] m_q [DIM][DIM];
   logic [DATA_W-1:0] m_d [DIM][DIM];
   logic [DATA_W-1:0] v_q [DIM];
   logic [DATA_W-1:0] v_d [DIM];
   logic [DATA_W-1:0] out_q [DIM];
   logic [DATA_W-1:0] out_d [DIM];
   logic [DIM-1:0]    osat_q, osat_d;
   logic [DATA_W-1:0] mac_res;
   logic              mac_sat;

   fixed_mac #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
      .clk_i (FSL_Clk),
      .rst_ni(FSL_Rst),
      .en_i  (state_q == COMPUTE),
      .clr_i (c_q == '0),
      .a_i   (m_q[r_q][c_q]),
      .b_i   (v_q[c_q]),
      .res_o (mac_res),
      .sat_o (mac_sat)
   );

   assign FSL_S_Read    = FSL_Rst && FSL_S_Exists && (state_q inside {IDLE, LOAD_M, LOAD_V});
   assign FSL_M_Write   = state_q == EMIT && !FSL_M_Full;
   assign FSL_M_Data    = state_q == EMIT ? out_q[r_q] : '0;
   assign FSL_M_Control = state_q == EMIT && osat_q[r_q];
   assign c_nx          = c_q == LAST ? '0 : c_q + 1'b1;
   assign r_nx          = r_q == LAST ? '0 : r_q + 1'b1;

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      m_d     = m_q;
      v_d     = v_q;
      out_d   = out_q;
      osat_d  = osat_q;
      if (FSL_S_Read && FSL_S_Control) begin
         m_d[0][0] = FSL_S_Data;
         r_d       = '0;
         c_d       = IW'(1);
         state_d   = LOAD_M;
      end else if (FSL_S_Read && state_q == IDLE) begin
         v_d[0]  = FSL_S_Data;
         r_d     = '0;
         c_d     = IW'(1);
         state_d = LOAD_V;
      end else if (FSL_S_Read && state_q == LOAD_M) begin
         m_d[r_q][c_q] = FSL_S_Data;
         c_d           = c_nx;
         r_d           = c_q == LAST ? r_nx : r_q;
         state_d       = (r_q == LAST && c_q == LAST) ? IDLE : LOAD_M;
      end else if (FSL_S_Read) begin
         v_d[c_q] = FSL_S_Data;
         c_d      = c_nx;
         state_d  = c_q == LAST ? COMPUTE : LOAD_V;
      end else if (state_q == COMPUTE) begin
         c_d = c_nx;
         if (c_q == LAST) begin
            out_d[r_q]  = mac_res;
            osat_d[r_q] = mac_sat;
            r_d         = r_nx;
            state_d     = r_q == LAST ? EMIT : COMPUTE;
         end
      end else if (FSL_M_Write) begin
         r_d     = r_nx;
         state_d = r_q == LAST ? IDLE : EMIT;
      end
   end

   always_ff @(posedge FSL_Clk or negedge FSL_Rst)
      if (!FSL_Rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         c_q     <= '0;
         m_q     <= '{default: '0};
         v_q     <= '{default: '0};
         out_q   <= '{default: '0};
         osat_q  <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         c_q     <= c_d;
         m_q     <= m_d;
         v_q     <= v_d;
         out_q   <= out_d;
         osat_q  <= osat_d;
      end

endmodule

// File: tb/tb_matvec_fsl.sv
// tb_matvec_fsl: directed checks of matvec_fsl with DIM=4, Q16.16 words.
module tb_matvec_fsl;

   logic        clk = 0, rst_n = 0, s_ctl = 0, s_exists = 0, m_full = 0;
   logic [31:0] s_data = '0;
   logic        s_read, m_ctl, m_write;
   logic [31:0] m_data;
   logic [31:0] exp_d [4];
   logic [3:0]  exp_c;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   matvec_fsl #(.DIM(4), .DATA_W(32), .FRAC_BITS(16)) dut (
      .FSL_Clk      (clk),
      .FSL_Rst      (rst_n),
      .FSL_S_Data   (s_data),
      .FSL_S_Control(s_ctl),
      .FSL_S_Exists (s_exists),
      .FSL_S_Read   (s_read),
      .FSL_M_Data   (m_data),
      .FSL_M_Control(m_ctl),
      .FSL_M_Write  (m_write),
      .FSL_M_Full   (m_full)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic c, input logic [31:0] d);
      int w = 0;
      @(negedge clk);
      s_ctl = c; s_data = d; s_exists = 1;
      #1;
      while (!s_read && w < 50) begin
         @(negedge clk); #1; w++;
      end
      chk("accept", s_read, 1);
      @(posedge clk);
      #1 s_exists = 0;
   endtask

   task automatic send_mat(input logic [31:0] dg, input logic [31:0] off);
      for (int i = 0; i < 16; i++) send(i == 0, (i % 5 == 0) ? dg : off);
   endtask

   task automatic send_vec(input logic [31:0] a, b, c, d);
      send(0, a); send(0, b); send(0, c); send(0, d);
   endtask

   task automatic set_exp(input logic [31:0] a, b, c, d, input logic [3:0] ec);
      exp_d[0] = a; exp_d[1] = b; exp_d[2] = c; exp_d[3] = d; exp_c = ec;
   endtask

   // k counts edges after the last vector word; the first write is due at edge 17.
   task automatic collect(input bit bp);
      int n = 0, j;
      for (int k = 1; k <= 80 && n < 4; k++) begin
         @(negedge clk);
         j = k - 17;
         m_full = bp && j >= 0 && (j < 5 || ((j - 5) % 2 == 1));
         #1;
         chk("s_read_busy", s_read, 0);
         if (j < 0) begin
            chk("compute_write", m_write, 0);
            chk("compute_data", m_data, 0);
         end else begin
            chk("write", m_write, !m_full);
            chk("data", m_data, exp_d[n]);
            chk("ctl", m_ctl, exp_c[n]);
            if (!m_full) n++;
         end
      end
      m_full = 0;
      chk("nwrites", n, 4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      s_exists = 1;
      #12;
      chk("rst_read", s_read, 0);
      chk("rst_write", m_write, 0);
      chk("rst_data", m_data, 0);
      chk("rst_ctl", m_ctl, 0);
      @(negedge clk);
      s_exists = 0; rst_n = 1;

      send_mat(32'h0001_0000, 0);
      send_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
      set_exp(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 4'b0000);
      collect(0);

      send_mat(32'h0002_0000, 0);
      send_vec(32'h0000_8000, 32'hFFFF_0000, 32'h0003_0000, 32'h0000_0000);
      set_exp(32'h0001_0000, 32'hFFFE_0000, 32'h0006_0000, 32'h0000_0000, 4'b0000);
      collect(0);
      send_vec(32'h0001_8000, 32'hFFFF_8000, 32'h0000_0010, 32'h7FFF_0000);
      set_exp(32'h0003_0000, 32'hFFFF_0000, 32'h0000_0020, 32'h7FFF_FFFF, 4'b1000);
      collect(0);

      send_mat(32'h0000_8000, 0);
      send_vec(32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002);
      set_exp(32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 32'h0000_0001, 4'b0000);
      collect(0);

      send_vec(32'h0002_0000, 32'h0004_0000, 32'h0006_0000, 32'h0008_0000);
      set_exp(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 4'b0000);
      s_data = 32'h0001_0000; s_ctl = 0; s_exists = 1;
      collect(1);
      send_vec(32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFE_0000);
      set_exp(32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 4'b0000);
      collect(0);

      send_mat(32'h7FFF_0000, 32'h7FFF_0000);
      send_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
      set_exp(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b1111);
      collect(0);
      send_vec(32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000);
      set_exp(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b1111);
      collect(0);

      send(0, 32'h0001_0000);
      send(0, 32'h0002_0000);
      send(1, 32'h7FFF_0000);
      for (int i = 0; i < 5; i++) send(0, 32'h7FFF_0000);
      send_mat(32'h0002_0000, 0);
      send_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
      set_exp(32'h0002_0000, 32'h0004_0000, 32'h0006_0000, 32'h0008_0000, 4'b0000);
      collect(0);

      send_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
      repeat (17) @(negedge clk);
      #1;
      chk("emit0_write", m_write, 1);
      chk("emit0_data", m_data, 32'h0002_0000);
      s_exists = 1;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("rst_mid_read", s_read, 0);
      chk("rst_mid_write", m_write, 0);
      chk("rst_mid_data", m_data, 0);
      chk("rst_mid_ctl", m_ctl, 0);
      @(negedge clk);
      #1 chk("rst_hold_write", m_write, 0);
      s_exists = 0; rst_n = 1;
      send_vec(32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
      set_exp(0, 0, 0, 0, 4'b0000);
      collect(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
